// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier Wishbone front end:
// register offsets, CTRL bit positions and the sequencer state encoding.
package spm_pkg;
  localparam int SPM_W = 32;

  localparam logic [7:0] OFF_X    = 8'h00;
  localparam logic [7:0] OFF_Y    = 8'h04;
  localparam logic [7:0] OFF_CTRL = 8'h08;
  localparam logic [7:0] OFF_PLO  = 8'h0C;
  localparam logic [7:0] OFF_PHI  = 8'h10;

  // CTRL write bits
  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_IE    = 2;
  // CTRL read bits
  localparam int CTRL_BUSY  = 0;
  localparam int CTRL_DONE  = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CLR, ST_RUN, ST_DONE} spm_state_e;
endpackage

// File: rtl/spm_seq.sv
// Sequencer for the serial multiplier: streams Y out LSB first and shifts
// the serial product back into a 2W-bit register.
module spm_seq
  import spm_pkg::*;
#(
  parameter int W       = SPM_W,
  parameter int SPM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   y,
  input  logic           p_bit,
  output logic           busy,
  output logic           done,
  output logic           clr,
  output logic           y_bit,
  output logic [2*W-1:0] p
);
  localparam int N  = 2*W + SPM_LAT;
  localparam int CW = $clog2(N);

  spm_state_e     state, nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   ysh;
  logic           last;

  assign last = (cnt == CW'(N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (start) nxt = ST_CLR;
      ST_CLR:  nxt = ST_RUN;
      ST_RUN:  if (last) nxt = ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Y shifts right with zero fill, so bits past W go out as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ysh <= '0;
      p   <= '0;
    end else begin
      case (state)
        ST_CLR: begin
          cnt <= '0;
          ysh <= y;
          p   <= '0;
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          ysh <= ysh >> 1;
          if (cnt >= CW'(SPM_LAT)) p <= {p_bit, p[2*W-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);
  assign clr   = (state == ST_CLR);
  assign y_bit = (state == ST_RUN) & ysh[0];
endmodule

// File: rtl/spm_wb_ctrl.sv
// Wishbone classic slave holding the multiplier operands, control/status and
// the reassembled product; sequencing is delegated to spm_seq.
module spm_wb_ctrl
  import spm_pkg::*;
#(
  parameter int          W         = SPM_W,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          SPM_LAT   = 1
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic [W-1:0] spm_x_o,
  output logic         spm_y_o,
  output logic         spm_clr_o,
  input  logic         spm_p_i,
  output logic         irq_o
);
  logic [W-1:0]   x, y;
  logic [2*W-1:0] p;
  logic           done, ie, busy, seq_done;
  logic           hit, req, wr, ctrl_wr, start;
  logic [7:0]     off;
  logic [31:0]    rdata;

  assign off     = wbs_adr_i[7:0];
  assign hit     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & hit;
  assign wr      = req & wbs_we_i;
  assign ctrl_wr = wr & (off == OFF_CTRL) & wbs_sel_i[0];
  assign start   = ctrl_wr & wbs_dat_i[CTRL_START] & ~busy;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      x    <= '0;
      y    <= '0;
      ie   <= 1'b0;
      done <= 1'b0;
    end else begin
      if (wr && !busy) begin
        for (int b = 0; b < 4; b++) begin
          if (wbs_sel_i[b]) begin
            if (off == OFF_X) x[8*b +: 8] <= wbs_dat_i[8*b +: 8];
            if (off == OFF_Y) y[8*b +: 8] <= wbs_dat_i[8*b +: 8];
          end
        end
      end
      if (ctrl_wr) ie <= wbs_dat_i[CTRL_IE];
      // A completion landing in the same cycle as a clear keeps done set.
      if (seq_done)                             done <= 1'b1;
      else if (ctrl_wr && wbs_dat_i[CTRL_CLR])  done <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_X:    rdata = 32'(x);
      OFF_Y:    rdata = 32'(y);
      OFF_CTRL: begin
        rdata[CTRL_BUSY] = busy;
        rdata[CTRL_DONE] = done;
        rdata[CTRL_IE]   = ie;
      end
      OFF_PLO:  rdata = p[31:0];
      OFF_PHI:  rdata = 32'(p >> 32);
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'd0;
    end
  end

  spm_seq #(.W(W), .SPM_LAT(SPM_LAT)) u_seq (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .start (start),
    .y     (y),
    .p_bit (spm_p_i),
    .busy  (busy),
    .done  (seq_done),
    .clr   (spm_clr_o),
    .y_bit (spm_y_o),
    .p     (p)
  );

  assign spm_x_o = x;
  assign irq_o   = done & ie;
endmodule

// File: tb/tb_spm_wb_ctrl.sv
// Directed bench for spm_wb_ctrl with a behavioural serial-parallel
// multiplier core (one cycle latency) hanging off the core-side ports.
module tb_spm_wb_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] spm_x;
  logic        spm_y, spm_clr, spm_p, irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spm_wb_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .spm_x_o   (spm_x),
    .spm_y_o   (spm_y),
    .spm_clr_o (spm_clr),
    .spm_p_i   (spm_p),
    .irq_o     (irq)
  );

  // Core model: accumulates X<<k for each serial Y bit k and returns
  // product bit k one cycle later.
  logic [127:0] acc, acc_nxt;
  logic [6:0]   k;
  assign acc_nxt = acc + (spm_y ? (128'(spm_x) << k) : 128'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      k     <= '0;
      spm_p <= 1'b0;
    end else if (spm_clr) begin
      acc   <= '0;
      k     <= '0;
      spm_p <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      spm_p <= acc_nxt[k];
      if (k != 7'd127) k <= k + 7'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output logic acked);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0;
    r = '0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        r = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic        a;
    wb_xfer(1'b1, BASE + 32'(o), d, s, r, a);
  endtask

  task automatic wb_rd(input logic [7:0] o, output logic [31:0] r);
    logic a;
    wb_xfer(1'b0, BASE + 32'(o), 32'd0, 4'hF, r, a);
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!irq && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        a;
    int          n;
    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;

    #12;
    chk("rst_outputs", 64'({ack, rdat, spm_x, spm_y, spm_clr, irq}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    wb_rd(8'h08, r); chk("rst_ctrl", 64'(r), 64'd0);
    wb_rd(8'h0C, r); chk("rst_plo", 64'(r), 64'd0);

    // 3 x 5, start with ie set, exact completion latency
    wb_wr(8'h00, 32'd3, 4'hF);
    wb_wr(8'h04, 32'd5, 4'hF);
    wb_rd(8'h00, r); chk("x_readback", 64'(r), 64'd3);
    chk("x_port", 64'(spm_x), 64'd3);
    wb_wr(8'h08, 32'h5, 4'hF);
    wait_irq(n); chk("done_latency", 64'(n), 64'd67);
    wb_rd(8'h0C, r); chk("p_lo_15", 64'(r), 64'd15);
    wb_rd(8'h10, r); chk("p_hi_15", 64'(r), 64'd0);
    wb_rd(8'h08, r); chk("ctrl_done", 64'(r), 64'h6);
    wb_wr(8'h08, 32'h6, 4'hF);
    chk("irq_clr_ack", 64'(irq), 64'd0);
    @(posedge clk); #1;
    chk("irq_clr_after", 64'(irq), 64'd0);
    wb_rd(8'h08, r); chk("ctrl_cleared", 64'(r), 64'h4);

    // byte lanes 0 and 2 only
    wb_wr(8'h00, 32'hAABB_CCDD, 4'b0101);
    chk("x_lanes", 64'(spm_x), 64'h00BB_00DD);

    // all-ones operands
    wb_wr(8'h00, 32'hFFFF_FFFF, 4'hF);
    wb_wr(8'h04, 32'hFFFF_FFFF, 4'hF);
    wb_wr(8'h08, 32'h5, 4'hF);
    wait_irq(n); chk("max_timeout", 64'(n < 200), 64'd1);
    wb_rd(8'h10, r); chk("p_hi_max", 64'(r), 64'hFFFF_FFFE);
    wb_rd(8'h0C, r); chk("p_lo_max", 64'(r), 64'h0000_0001);

    // start + done-clear in one write, then writes while busy
    wb_wr(8'h00, 32'd6, 4'hF);
    wb_wr(8'h04, 32'd4, 4'hF);
    wb_wr(8'h08, 32'h7, 4'hF);
    wb_rd(8'h08, r); chk("start_and_clear", 64'(r), 64'h5);
    wb_xfer(1'b1, BASE + 32'h00, 32'd7, 4'hF, r, a); chk("busy_x_ack", 64'(a), 64'd1);
    wb_rd(8'h00, r); chk("busy_x_dropped", 64'(r), 64'd6);
    wb_xfer(1'b1, BASE + 32'h08, 32'h5, 4'hF, r, a); chk("busy_start_ack", 64'(a), 64'd1);
    wait_irq(n); chk("busy_timeout", 64'(n < 200), 64'd1);
    wb_rd(8'h0C, r); chk("p_lo_busy", 64'(r), 64'd24);
    wb_rd(8'h08, r); chk("single_run", 64'(r), 64'h6);
    wb_wr(8'h08, 32'h6, 4'hF);
    repeat (80) @(posedge clk);
    #1;
    wb_rd(8'h08, r); chk("no_second_done", 64'(r), 64'h4);

    // 2 x 4 interrupt set and cleared
    wb_wr(8'h00, 32'd2, 4'hF);
    wb_wr(8'h04, 32'd4, 4'hF);
    wb_wr(8'h08, 32'h5, 4'hF);
    wait_irq(n); chk("irq_2x4", 64'(irq), 64'd1);
    wb_rd(8'h0C, r); chk("p_lo_8", 64'(r), 64'd8);
    wb_wr(8'h08, 32'h6, 4'hF);
    chk("irq_2x4_clr", 64'(irq), 64'd0);

    // reset in the middle of a run
    wb_wr(8'h00, 32'd3, 4'hF);
    wb_wr(8'h04, 32'd5, 4'hF);
    wb_wr(8'h08, 32'h5, 4'hF);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrun_rst_outputs", 64'({ack, rdat, spm_x, spm_y, spm_clr, irq}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    wb_rd(8'h08, r); chk("post_rst_ctrl", 64'(r), 64'd0);
    wb_rd(8'h0C, r); chk("post_rst_plo", 64'(r), 64'd0);
    wb_rd(8'h10, r); chk("post_rst_phi", 64'(r), 64'd0);

    // unmapped offset in window, and an address outside it
    wb_xfer(1'b0, BASE + 32'h1C, 32'd0, 4'hF, r, a);
    chk("hole_ack", 64'(a), 64'd1);
    chk("hole_data", 64'(r), 64'd0);
    wb_xfer(1'b0, BASE + 32'h100, 32'd0, 4'hF, r, a);
    chk("outside_no_ack", 64'(a), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
